core_sched: RTL
===============

CORE_SCHED -- requirements
Module: core_sched

Interface
REQ-001 clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 pr0, pr1  input  3 each  pause/resume request per core: [2]=valid, [1]=0 pause / 1 resume, [0]=target core index.
REQ-004 halt0, halt1  input  1 each  core halted flag.
REQ-005 wen0/waddr0/wdata0, wen1/waddr1/wdata1  input  1/15/16 each  per-core store request, bits [15:1] of address.
REQ-006 stall0, stall1  output  3 each  stall_num driven into each core; 0 = run, 6 = full freeze.
REQ-007 mem_wen, mem_waddr, mem_wdata  output  1/15/16  shared memory write port.
REQ-008 gnt  output  2  one-hot store grant this cycle; bit n = core n.
REQ-009 paused  output  2  registered pause state per core.
REQ-010 deadlock  output  1  both non-halted cores paused.
REQ-011 done  output  1  both cores halted.
REQ-012 perf_pause0, perf_pause1, perf_conflict  output  16 each  performance counters.

Function
REQ-013 Per-core FSM with states RUN, PAUSED, HALTED; reset state RUN.
REQ-014 RUN->PAUSED on a valid pause targeting that core; PAUSED->RUN on a valid resume targeting it; RUN or PAUSED->HALTED when haltN=1; HALTED is terminal until rst.
REQ-015 State changes take effect the cycle after the request; paused[n] and the stall freeze start on that cycle.
REQ-016 Same target, same cycle, pause and resume both valid: resume wins, state becomes or stays RUN.
REQ-017 Requests targeting a HALTED core are ignored; self-pause is legal; requests from a core while its stallN is nonzero are ignored.
REQ-018 stallN = 6 when core N is PAUSED or loses store arbitration this cycle, else 0; HALTED cores get 0.
REQ-019 Store arbitration is combinational and uses only wenN from a RUN core.
REQ-020 If one core requests a store, it is granted; mem_* = that core's signals.
REQ-021 If both cores request a store, grant the core other than last_grant; the loser gets stall=6 for that cycle and retries the next cycle.
REQ-022 last_grant updates only on conflict cycles; reset value 1, so core0 wins the first conflict.
REQ-023 With no grant: mem_wen=0, mem_waddr=0, mem_wdata=0, gnt=0.
REQ-024 deadlock = paused==2'b11, combinational from registered state.
REQ-025 done = both FSMs HALTED, registered, asserted the cycle after the second halt.
REQ-026 Counters saturate at 16'hFFFF and do not wrap.

Reset
REQ-027 rst asynchronously forces both FSMs to RUN and last_grant to 1, and clears all counters.
REQ-028 While rst is asserted: stall=0, mem_wen=0, gnt=0, paused=0, deadlock=0, done=0.
REQ-029 rst during a conflict drops the pending store; the core retries after reset is released.

Configuration
REQ-030 Macro CORE_SCHED_PERF_EN: when defined, perf_pauseN counts cycles with core N PAUSED and perf_conflict counts arbitration conflicts.
REQ-031 When CORE_SCHED_PERF_EN is undefined, all perf_* outputs are tied 0 and no counter flops exist.
REQ-032 All other behaviour is identical with and without CORE_SCHED_PERF_EN.

Verification
REQ-033 Pause: pr0=3'b101 for 1 cycle -> next cycle paused=2'b10, stall1=6, stall0=0; then pr0=3'b111 -> next cycle paused=0, stall1=0.
REQ-034 Conflict: wen0=wen1=1, waddr0=15'h10, waddr1=15'h20 for 2 cycles after reset.
  - cycle 1: gnt=01, mem_waddr=15'h10, stall1=6.
  - cycle 2: gnt=10, mem_waddr=15'h20, stall0=6.
REQ-035 Simultaneous requests: pr0=3'b101 and pr1=3'b111 in the same cycle -> core1 stays RUN, paused=0.
REQ-036 Deadlock: pr0=3'b100 then pr1=3'b101 -> paused=11 and deadlock=1; further valid resumes from cores are ignored until rst.
REQ-037 Halt: halt0=1, then halt1=1 three cycles later -> done rises exactly 1 cycle after halt1; a pause targeting core0 after its halt leaves paused[0]=0.
REQ-038 Perf and reset: with CORE_SCHED_PERF_EN defined, core1 paused 5 cycles -> perf_pause1=5; rst mid-pause -> all counters 0 and paused=0 immediately (asynchronously).

Source files
------------

// File: rtl/core_sched.sv
// Two-core pause/resume scheduler with a shared store port and per-core stall control.
// Optional performance counters are enabled by defining CORE_SCHED_PERF_EN.
module core_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  pr0,
  input  logic [2:0]  pr1,
  input  logic        halt0,
  input  logic        halt1,
  input  logic        wen0,
  input  logic [14:0] waddr0,
  input  logic [15:0] wdata0,
  input  logic        wen1,
  input  logic [14:0] waddr1,
  input  logic [15:0] wdata1,
  output logic [2:0]  stall0,
  output logic [2:0]  stall1,
  output logic        mem_wen,
  output logic [14:0] mem_waddr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  paused,
  output logic        deadlock,
  output logic        done,
  output logic [15:0] perf_pause0,
  output logic [15:0] perf_pause1,
  output logic [15:0] perf_conflict
);

  typedef enum logic [1:0] {RUN = 2'd0, PAUSED = 2'd1, HALTED = 2'd2} state_t;

  state_t      state0_r, state1_r, state0_nxt_s, state1_nxt_s;
  logic        last_grant_r;
  logic        done_r;
  logic [1:0]  req_s, gnt_s, pause_s, resume_s;
  logic        conflict_s, v0_s, v1_s;
  logic [2:0]  stall0_s, stall1_s;

  // Halt dominates; a resume beats a pause aimed at the same core.
  function automatic state_t next_state(state_t cur, logic halt, logic pause, logic resume);
    state_t nxt;
    case (cur)
      RUN:     nxt = halt ? HALTED : ((pause && !resume) ? PAUSED : RUN);
      PAUSED:  nxt = halt ? HALTED : (resume ? RUN : PAUSED);
      HALTED:  nxt = HALTED;
      default: nxt = RUN;
    endcase
    return nxt;
  endfunction

  // Store arbitration: only running cores compete; reset masks everything.
  always_comb begin
    req_s      = 2'b00;
    gnt_s      = 2'b00;
    conflict_s = 1'b0;
    if (!rst) begin
      req_s[0] = wen0 && (state0_r == RUN);
      req_s[1] = wen1 && (state1_r == RUN);
    end else begin
      req_s = 2'b00;
    end
    conflict_s = req_s[0] && req_s[1];
    if (conflict_s) begin
      gnt_s = last_grant_r ? 2'b01 : 2'b10;
    end else begin
      gnt_s = req_s;
    end
  end

  // Shared memory port mux and stall generation.
  always_comb begin
    mem_wen   = 1'b0;
    mem_waddr = 15'd0;
    mem_wdata = 16'd0;
    stall0_s  = 3'd0;
    stall1_s  = 3'd0;
    if (gnt_s[0]) begin
      mem_wen   = 1'b1;
      mem_waddr = waddr0;
      mem_wdata = wdata0;
    end else if (gnt_s[1]) begin
      mem_wen   = 1'b1;
      mem_waddr = waddr1;
      mem_wdata = wdata1;
    end else begin
      mem_wen   = 1'b0;
    end
    if (!rst && ((state0_r == PAUSED) || (req_s[0] && !gnt_s[0]))) begin
      stall0_s = 3'd6;
    end else begin
      stall0_s = 3'd0;
    end
    if (!rst && ((state1_r == PAUSED) || (req_s[1] && !gnt_s[1]))) begin
      stall1_s = 3'd6;
    end else begin
      stall1_s = 3'd0;
    end
  end

  // Decode requests; a stalled core cannot issue them.
  always_comb begin
    v0_s        = pr0[2] && (stall0_s == 3'd0);
    v1_s        = pr1[2] && (stall1_s == 3'd0);
    pause_s[0]  = (v0_s && !pr0[1] && !pr0[0]) || (v1_s && !pr1[1] && !pr1[0]);
    pause_s[1]  = (v0_s && !pr0[1] &&  pr0[0]) || (v1_s && !pr1[1] &&  pr1[0]);
    resume_s[0] = (v0_s &&  pr0[1] && !pr0[0]) || (v1_s &&  pr1[1] && !pr1[0]);
    resume_s[1] = (v0_s &&  pr0[1] &&  pr0[0]) || (v1_s &&  pr1[1] &&  pr1[0]);
    state0_nxt_s = next_state(state0_r, halt0, pause_s[0], resume_s[0]);
    state1_nxt_s = next_state(state1_r, halt1, pause_s[1], resume_s[1]);
  end

  // State, arbitration history and completion flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state0_r     <= RUN;
      state1_r     <= RUN;
      last_grant_r <= 1'b1;
      done_r       <= 1'b0;
    end else begin
      state0_r     <= state0_nxt_s;
      state1_r     <= state1_nxt_s;
      last_grant_r <= conflict_s ? gnt_s[1] : last_grant_r;
      done_r       <= (state0_nxt_s == HALTED) && (state1_nxt_s == HALTED);
    end
  end

  assign stall0   = stall0_s;
  assign stall1   = stall1_s;
  assign gnt      = gnt_s;
  assign paused   = {state1_r == PAUSED, state0_r == PAUSED};
  assign deadlock = &paused;
  assign done     = done_r;

`ifdef CORE_SCHED_PERF_EN
  logic [15:0] perf_pause0_r, perf_pause1_r, perf_conflict_r;

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_pause0_r   <= 16'd0;
      perf_pause1_r   <= 16'd0;
      perf_conflict_r <= 16'd0;
    end else begin
      if ((state0_r == PAUSED) && (perf_pause0_r != 16'hFFFF)) perf_pause0_r <= perf_pause0_r + 16'd1;
      if ((state1_r == PAUSED) && (perf_pause1_r != 16'hFFFF)) perf_pause1_r <= perf_pause1_r + 16'd1;
      if (conflict_s && (perf_conflict_r != 16'hFFFF)) perf_conflict_r <= perf_conflict_r + 16'd1;
    end
  end

  assign perf_pause0   = perf_pause0_r;
  assign perf_pause1   = perf_pause1_r;
  assign perf_conflict = perf_conflict_r;
`else
  assign perf_pause0   = 16'd0;
  assign perf_pause1   = 16'd0;
  assign perf_conflict = 16'd0;
`endif

endmodule
